lutram_stress_driver: RTL and testbench

- Self-checking traffic initiator for the LUTRAM stress array.
- Drives the array's addr/we/wdat port and checks its rdat port.
- Runs a two-pass write-all / read-all-and-compare sequence over every location, then reports pass/fail, error count and first failing address.
- Sits between board-level start/status pins and the LUTRAM array in the capacity stress-test top.

---
 rtl/lutram_stress_driver.sv | 192 +++++++++++++++++++
 tb/tb_lutram_stress_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lutram_stress_driver.sv
// Self-checking traffic initiator for the LUTRAM stress array: two passes of
// write-all then read-and-compare, reporting error count and first failing address.
module lutram_stress_driver #(
   parameter  int unsigned LUTRAM16X10 = 265,
   parameter  int unsigned RD_LAT      = 1,
   localparam int unsigned DEPTH       = LUTRAM16X10 * 16,
   localparam int unsigned ADDR_W      = $clog2(LUTRAM16X10 * 16)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [9:0]        mem_wdat,
   input  logic [9:0]        mem_rdat
);

   localparam int unsigned       PL   = (RD_LAT == 0) ? 1 : RD_LAT;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_DONE} state_t;

   state_t              state_q, state_d;
   logic                pidx_q, pidx_d;
   logic [1:0]          drain_q, drain_d;
   logic [ADDR_W-1:0]   addr_d, addr_inc;
   logic                we_d;
   logic [9:0]          wdat_d;
   logic                iss_vld, clr, pass_end;
   logic                cmp_vld;
   logic [ADDR_W-1:0]   cmp_addr;
   logic [9:0]          cmp_exp;
   logic                mismatch;
   logic                err_seen;

   function automatic logic [9:0] pattern(input logic [ADDR_W-1:0] a, input logic p);
      logic [9:0] p0;
      p0 = 10'(a) ^ 10'h155;
      return p ? ~p0 : p0;
   endfunction

   assign addr_inc = mem_addr + ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pidx_q   <= 1'b0;
         drain_q  <= '0;
         mem_addr <= '0;
         mem_we   <= 1'b0;
         mem_wdat <= '0;
      end else begin
         state_q  <= state_d;
         pidx_q   <= pidx_d;
         drain_q  <= drain_d;
         mem_addr <= addr_d;
         mem_we   <= we_d;
         mem_wdat <= wdat_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pidx_d   = pidx_q;
      drain_d  = drain_q;
      addr_d   = mem_addr;
      we_d     = 1'b0;
      wdat_d   = mem_wdat;
      iss_vld  = 1'b0;
      clr      = 1'b0;
      pass_end = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_WRITE;
               pidx_d  = 1'b0;
               addr_d  = '0;
               we_d    = 1'b1;
               wdat_d  = pattern('0, 1'b0);
               clr     = 1'b1;
            end
         end
         ST_WRITE: begin
            if (mem_addr == LAST) begin
               state_d = ST_READ;
               addr_d  = '0;
            end else begin
               addr_d = addr_inc;
               we_d   = 1'b1;
               wdat_d = pattern(addr_inc, pidx_q);
            end
         end
         ST_READ: begin
            iss_vld = 1'b1;
            if (mem_addr == LAST) begin
               if (RD_LAT == 0) begin
                  pass_end = 1'b1;
               end else begin
                  state_d = ST_DRAIN;
                  drain_d = '0;
               end
            end else begin
               addr_d = addr_inc;
            end
         end
         ST_DRAIN: begin
            if (drain_q == 2'(RD_LAT - 1)) pass_end = 1'b1;
            else                           drain_d  = drain_q + 2'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      // End of a read pass: second write pass or finish
      if (pass_end) begin
         if (!pidx_q) begin
            state_d = ST_WRITE;
            pidx_d  = 1'b1;
            addr_d  = '0;
            we_d    = 1'b1;
            wdat_d  = pattern('0, 1'b1);
         end else begin
            state_d = ST_DONE;
         end
      end
   end

   if (RD_LAT == 0) begin : g_comb
      always_comb begin
         cmp_vld  = iss_vld;
         cmp_addr = mem_addr;
         cmp_exp  = pattern(mem_addr, pidx_q);
      end
   end else begin : g_pipe
      logic              pv_q [PL];
      logic [ADDR_W-1:0] pa_q [PL];
      logic [9:0]        pe_q [PL];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int unsigned i = 0; i < PL; i++) begin
               pv_q[i] <= 1'b0;
               pa_q[i] <= '0;
               pe_q[i] <= '0;
            end
         end else begin
            pv_q[0] <= iss_vld;
            pa_q[0] <= mem_addr;
            pe_q[0] <= pattern(mem_addr, pidx_q);
            for (int unsigned i = 1; i < PL; i++) begin
               pv_q[i] <= pv_q[i-1];
               pa_q[i] <= pa_q[i-1];
               pe_q[i] <= pe_q[i-1];
            end
         end
      end

      always_comb begin
         cmp_vld  = pv_q[PL-1];
         cmp_addr = pa_q[PL-1];
         cmp_exp  = pe_q[PL-1];
      end
   end

   assign mismatch = cmp_vld && (mem_rdat != cmp_exp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt        <= '0;
         first_err_addr <= '0;
         err_seen       <= 1'b0;
      end else if (clr) begin
         err_cnt        <= '0;
         first_err_addr <= '0;
         err_seen       <= 1'b0;
      end else if (mismatch) begin
         if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
         if (!err_seen) begin
            first_err_addr <= cmp_addr;
            err_seen       <= 1'b1;
         end
      end
   end

   assign busy = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign done = (state_q == ST_DONE);
   assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_lutram_stress_driver.sv
// Bench for lutram_stress_driver: three instances (RD_LAT 0/1/3) on small arrays
// with fault-injecting behavioural memories, table-driven and randomized runs.
module tb_lutram_stress_driver;
   localparam int N = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start_v [N];
   logic        busy_v  [N];
   logic        done_v  [N];
   logic        pass_v  [N];
   logic [15:0] err_v   [N];
   logic [4:0]  first_v [N];
   logic [4:0]  addr_v  [N];
   logic        we_v    [N];
   logic [9:0]  wdat_v  [N];

   bit          st5;
   logic [31:0] zm, xm;
   logic [9:0]  xv;

   int total = 0;
   int bad   = 0;

   function automatic logic [9:0] fault_rd(input logic [4:0] a, input logic [9:0] v,
                                           input logic [31:0] z, input logic [31:0] x,
                                           input logic [9:0] f);
      logic [9:0] r;
      r = z[a] ? 10'h000 : v;
      if (x[a]) r = r ^ f;
      return r;
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;
      logic [9:0] mem [32];
      logic [9:0] r0, rdat;
      logic [9:0] dly [3];

      lutram_stress_driver #(.LUTRAM16X10(2), .RD_LAT(LAT)) dut (
         .clk            (clk),
         .rst_n          (rst_n),
         .start          (start_v[g]),
         .busy           (busy_v[g]),
         .done           (done_v[g]),
         .pass           (pass_v[g]),
         .err_cnt        (err_v[g]),
         .first_err_addr (first_v[g]),
         .mem_addr       (addr_v[g]),
         .mem_we         (we_v[g]),
         .mem_wdat       (wdat_v[g]),
         .mem_rdat       (rdat)
      );

      always @(posedge clk)
         if (we_v[g]) mem[addr_v[g]] <= (st5 && addr_v[g] == 5'd5) ? (wdat_v[g] & ~10'h008) : wdat_v[g];

      assign r0 = fault_rd(addr_v[g], mem[addr_v[g]], zm, xm, xv);

      always @(posedge clk) begin
         dly[0] <= r0;
         dly[1] <= dly[0];
         dly[2] <= dly[1];
      end

      assign rdat = (LAT == 0) ? r0 : dly[(LAT == 0) ? 0 : LAT - 1];
   end

   typedef struct {
      int          sel;
      int          mode;   // 0 pulse, 1 held high, 2 pulse plus re-pulse mid-READ
      bit          st5;
      logic [31:0] zm;
      logic [31:0] xm;
      logic [9:0]  xv;
      int          len;
      int          err;
      int          first;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: apply each pass's pattern through the faulty memory and count mismatches
   function automatic void model(input bit s5, input logic [31:0] z, input logic [31:0] x,
                                 input logic [9:0] f, output int cnt, output int first);
      bit seen;
      seen  = 1'b0;
      cnt   = 0;
      first = 0;
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a < 32; a++) begin
            logic [9:0] w, s, r;
            w = 10'(a) ^ 10'h155;
            if (p == 1) w = ~w;
            s = (s5 && a == 5) ? (w & ~10'h008) : w;
            r = fault_rd(5'(a), s, z, x, f);
            if (r != w) begin
               cnt++;
               if (!seen) begin
                  seen  = 1'b1;
                  first = a;
               end
            end
         end
      end
   endfunction

   function automatic int len_of(input int sel);
      int lat;
      lat = (sel == 0) ? 0 : (sel == 1) ? 1 : 3;
      return 2 * (2 * 32 + lat);
   endfunction

   task automatic run(input int sel, input int mode, input int exp_len, input int exp_err,
                      input int exp_first);
      int cyc;
      @(negedge clk);
      start_v[sel] = 1'b1;
      @(posedge clk);
      #1;
      check("busy_at_start",  32'(busy_v[sel]),  1);
      check("done_at_start",  32'(done_v[sel]),  0);
      check("err_cleared",    32'(err_v[sel]),   0);
      check("first_cleared",  32'(first_v[sel]), 0);
      if (mode != 1) start_v[sel] = 1'b0;
      cyc = 0;
      while (done_v[sel] !== 1'b1 && cyc < 1000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (mode == 2 && cyc == 50) start_v[sel] = 1'b1;
         if (mode == 2 && cyc == 52) start_v[sel] = 1'b0;
      end
      start_v[sel] = 1'b0;
      check("run_length",     cyc,               exp_len);
      check("err_cnt",        32'(err_v[sel]),   exp_err);
      check("first_err_addr", 32'(first_v[sel]), exp_first);
      check("pass",           32'(pass_v[sel]),  (exp_err == 0) ? 1 : 0);
      check("busy_at_done",   32'(busy_v[sel]),  0);
      @(posedge clk);
      #1;
      check("done_held",      32'(done_v[sel]),  1);
   endtask

   initial begin
      vec_t v;
      int   e, f;

      rst_n = 1'b0;
      for (int i = 0; i < N; i++) start_v[i] = 1'b0;
      st5 = 1'b0;
      zm  = '0;
      xm  = '0;
      xv  = '0;

      vecs.push_back('{1, 0, 1'b0, 32'h0,         32'h0, 10'h0, 130, 0, 0});
      vecs.push_back('{1, 0, 1'b1, 32'h0,         32'h0, 10'h0, 130, 1, 5});
      vecs.push_back('{1, 0, 1'b0, 32'h0010_0080, 32'h0, 10'h0, 130, 4, 7});
      vecs.push_back('{0, 0, 1'b0, 32'h0,         32'h0, 10'h0, 128, 0, 0});
      vecs.push_back('{2, 0, 1'b0, 32'h0,         32'h0, 10'h0, 134, 0, 0});
      vecs.push_back('{1, 1, 1'b0, 32'h0,         32'h0, 10'h0, 130, 0, 0});
      vecs.push_back('{1, 2, 1'b0, 32'h0010_0080, 32'h0, 10'h0, 130, 4, 7});
      vecs.push_back('{1, 0, 1'b0, 32'h0,         32'h0, 10'h0, 130, 0, 0});
      for (int i = 0; i < 6; i++) begin
         v.sel  = int'($urandom_range(0, 2));
         v.mode = int'($urandom_range(0, 2));
         v.st5  = bit'($urandom_range(0, 1));
         v.zm   = $urandom & $urandom & $urandom;
         v.xm   = $urandom & $urandom;
         v.xv   = 10'($urandom_range(1, 1023));
         model(v.st5, v.zm, v.xm, v.xv, e, f);
         v.len   = len_of(v.sel);
         v.err   = e;
         v.first = f;
         vecs.push_back(v);
      end

      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < N; g++) begin
         check("rst_busy",  32'(busy_v[g]),  0);
         check("rst_done",  32'(done_v[g]),  0);
         check("rst_pass",  32'(pass_v[g]),  0);
         check("rst_err",   32'(err_v[g]),   0);
         check("rst_first", 32'(first_v[g]), 0);
         check("rst_we",    32'(we_v[g]),    0);
         check("rst_addr",  32'(addr_v[g]),  0);
         check("rst_wdat",  32'(wdat_v[g]),  0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         st5 = vecs[i].st5;
         zm  = vecs[i].zm;
         xm  = vecs[i].xm;
         xv  = vecs[i].xv;
         run(vecs[i].sel, vecs[i].mode, vecs[i].len, vecs[i].err, vecs[i].first);
      end

      // Reset during the second write pass of a faulty run
      st5 = 1'b0;
      zm  = 32'h0010_0080;
      xm  = '0;
      @(negedge clk);
      start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      repeat (84) @(negedge clk);
      check("mid_busy",      32'(busy_v[1]), 1);
      check("mid_we",        32'(we_v[1]),   1);
      check("mid_err_cnt",   32'(err_v[1]),  2);
      rst_n = 1'b0;
      #1;
      check("arst_we",    32'(we_v[1]),    0);
      check("arst_busy",  32'(busy_v[1]),  0);
      check("arst_done",  32'(done_v[1]),  0);
      check("arst_err",   32'(err_v[1]),   0);
      check("arst_first", 32'(first_v[1]), 0);
      check("arst_addr",  32'(addr_v[1]),  0);
      check("arst_wdat",  32'(wdat_v[1]),  0);
      @(negedge clk);
      check("arst_we_held", 32'(we_v[1]), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_busy", 32'(busy_v[1]), 0);
      check("post_rst_done", 32'(done_v[1]), 0);
      check("post_rst_we",   32'(we_v[1]),   0);
      zm = '0;
      run(1, 0, 130, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
